// File: rtl/bsg_aes_pkg.sv
// Shared AES result-path constants and the result serializer state type.
package bsg_aes_pkg;

   localparam int aes_block_width_gp  = 128;
   localparam int aes_key_width_gp    = 256;
   localparam int aes_round_keys_gp   = 15;
   localparam int aes_result_width_gp = 2048;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } bsg_aes_ser_state_e;

   // Words per output frame: full ciphertext + key chain, or ciphertext only.
   function automatic int frame_words(input int width, input bit emit_key_chain);
      return (emit_key_chain ? aes_result_width_gp : aes_block_width_gp) / width;
   endfunction

endpackage

// File: rtl/bsg_aes_result_serializer.sv
// Serializes one 2048-bit AES result into width_p-bit words, most significant
// word first, with a valid/ready output and single-beat back-to-back refill.
module bsg_aes_result_serializer
   import bsg_aes_pkg::*;
#(
   parameter int width_p          = 64,
   parameter int emit_key_chain_p = 1
)
(
   input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic [aes_result_width_gp-1:0] data_i,
   input  logic                           v_i,
   output logic                           yumi_o,
   output logic [width_p-1:0]             data_o,
   output logic                           v_o,
   input  logic                           ready_i,
   output logic                           last_o
);

   localparam int frame_words_lp = frame_words(width_p, emit_key_chain_p != 0);
   localparam int idx_width_lp   = (frame_words_lp > 1) ? $clog2(frame_words_lp) : 1;
   localparam logic [idx_width_lp-1:0] last_idx_lp = idx_width_lp'(frame_words_lp - 1);

   bsg_aes_ser_state_e        state_r, state_n;
   logic [idx_width_lp-1:0]   idx_r;
   logic [width_p-1:0]        words_r [frame_words_lp];
   logic                      sending;
   logic                      at_last;
   logic                      final_beat;

   assign sending    = (state_r == SEND);
   assign at_last    = (idx_r == last_idx_lp);
   assign final_beat = sending & ready_i & at_last;

   // Accept a new frame when idle, or in the same cycle the last word leaves.
   assign yumi_o = v_i & ~reset_i & (~sending | final_beat);

   always_ff @(posedge clk_i) begin
      if (reset_i)
         state_r <= IDLE;
      else
         state_r <= state_n;
   end

   always_comb begin
      state_n = state_r;
      case (state_r)
         IDLE:    if (yumi_o) state_n = SEND;
         SEND:    if (final_beat & ~yumi_o) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i)
         idx_r <= '0;
      else if (yumi_o)
         idx_r <= '0;
      else if (sending & ready_i & ~at_last)
         idx_r <= idx_r + 1'b1;
   end

   // Buffer is held as pre-split words; only the words a frame emits are kept.
   always_ff @(posedge clk_i) begin
      if (yumi_o)
         for (int unsigned i = 0; i < frame_words_lp; i++)
            words_r[i] <= data_i[aes_result_width_gp-1 - i*width_p -: width_p];
   end

   always_comb begin
      v_o    = sending;
      last_o = sending & at_last;
      data_o = words_r[idx_r];
   end

endmodule

// File: tb/tb_bsg_aes_result_serializer.sv
// Bench for bsg_aes_result_serializer: four configurations checked every cycle
// against a queue-of-expected-words model of the output stream.
module tb_bsg_aes_result_serializer;

   localparam int RW = 2048;
   localparam int W_T [4] = '{64, 64, 128, 32};
   localparam int E_T [4] = '{1, 0, 1, 1};

   function automatic int nw(input int d);
      return ((E_T[d] != 0) ? 2048 : 128) / W_T[d];
   endfunction

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    vin, rdy, yumi, vo, lo;
   logic [RW-1:0] din [4];
   int            n_checks = 0;
   int            n_errors = 0;
   int            exp_words [4];

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [RW-1:0] rand_frame();
      logic [RW-1:0] f;
      for (int i = 0; i < RW/32; i++) f[i*32 +: 32] = $urandom;
      return f;
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int W = W_T[g];
      localparam int E = E_T[g];
      localparam int N = ((E != 0) ? 2048 : 128) / W;

      logic [W-1:0] dout;
      logic [W-1:0] q [$];
      int           words = 0;

      bsg_aes_result_serializer #(.width_p(W), .emit_key_chain_p(E)) u_dut (
         .clk_i   (clk),
         .reset_i (rst),
         .data_i  (din[g]),
         .v_i     (vin[g]),
         .yumi_o  (yumi[g]),
         .data_o  (dout),
         .v_o     (vo[g]),
         .ready_i (rdy[g]),
         .last_o  (lo[g])
      );

      // Model: the words still owed downstream; a frame may be taken when the
      // queue is empty or its final word is leaving this cycle.
      always @(negedge clk) begin
         logic          exp_v, exp_y, hs;
         logic [RW-1:0] tmp;
         exp_v = (q.size() != 0);
         exp_y = vin[g] && !rst && (q.size() == 0 || (q.size() == 1 && rdy[g]));
         chk($sformatf("v_o[%0d]", g), 128'(vo[g]), 128'(exp_v));
         chk($sformatf("yumi_o[%0d]", g), 128'(yumi[g]), 128'(exp_y));
         if (exp_v) begin
            chk($sformatf("last_o[%0d]", g), 128'(lo[g]), 128'(q.size() == 1));
            chk($sformatf("data_o[%0d]", g), 128'(dout), 128'(q[0]));
         end
         hs = exp_v && rdy[g];
         if (rst)
            q.delete();
         else begin
            if (hs) begin
               void'(q.pop_front());
               words++;
            end
            if (exp_y) begin
               tmp = din[g];
               for (int k = 0; k < N; k++) begin
                  q.push_back(tmp[RW-1 -: W]);
                  tmp = tmp << W;
               end
            end
         end
      end
   end

   // mode: 0 = ready always high, 1 = ready pattern 1,0,0,1, 2 = random ready
   task automatic run(input int d, input int frames, input int mode, input int max_cycles);
      int sent = 0;
      int cyc  = 0;
      logic took;
      logic [3:0] pat;
      pat = 4'b1001;
      din[d] = rand_frame();
      vin[d] = 1'b1;
      while ((sent < frames || vo[d]) && cyc < max_cycles) begin
         rdy[d] = (mode == 0) ? 1'b1 : (mode == 1) ? pat[3 - (cyc % 4)] : 1'($urandom_range(0, 1));
         #2;
         took = yumi[d];
         @(posedge clk); #1;
         cyc++;
         if (took) begin
            sent++;
            exp_words[d] += nw(d);
            if (sent < frames) din[d] = rand_frame();
            else vin[d] = 1'b0;
         end
      end
      vin[d] = 1'b0;
      chk($sformatf("run_timeout[%0d]", d), 128'(cyc < max_cycles), 128'(1));
   endtask

   initial begin
      logic [RW-1:0] kf;
      int wcount, last_at, guard;

      rst = 1'b1; vin = '0; rdy = '0;
      for (int d = 0; d < 4; d++) begin
         din[d] = '0;
         exp_words[d] = 0;
      end

      // reset: outputs quiet, v_i ignored while reset is high
      @(posedge clk); #1;
      vin[0] = 1'b1;
      #2;
      chk("reset_yumi", 128'(yumi[0]), 128'(0));
      @(posedge clk); #1;
      vin[0] = 1'b0;
      chk("reset_v_o", 128'(vo), 128'(0));
      chk("reset_last", 128'(lo), 128'(0));
      rst = 1'b0;

      // single frame, known ciphertext + incrementing key-chain bytes
      kf[RW-1 -: 128] = 128'h00112233445566778899AABBCCDDEEFF;
      for (int b = 0; b < 240; b++) kf[1919 - 8*b -: 8] = 8'(b);
      din[0] = kf; rdy[0] = 1'b1; vin[0] = 1'b1;
      #2;
      chk("t1_yumi", 128'(yumi[0]), 128'(1));
      @(posedge clk); #1;
      vin[0] = 1'b0;
      exp_words[0] += 32;
      chk("t1_word0", 128'(g_dut[0].dout), 128'(64'h0011223344556677));
      chk("t1_yumi_pulse", 128'(yumi[0]), 128'(0));
      wcount = 0; last_at = -1; guard = 0;
      while (vo[0] && guard < 100) begin
         if (lo[0]) last_at = wcount;
         wcount++; guard++;
         @(posedge clk); #1;
      end
      chk("t1_word_count", 128'(wcount), 128'(32));
      chk("t1_last_pos", 128'(last_at), 128'(31));

      // ciphertext-only frames
      run(1, 2, 0, 100);
      // back-pressure with 1,0,0,1 ready pattern
      run(0, 1, 1, 400);
      // back-to-back frames with v_i held high
      run(0, 2, 0, 200);

      // reset after word 10 of 32
      din[0] = rand_frame(); rdy[0] = 1'b1; vin[0] = 1'b1;
      @(posedge clk); #1;
      vin[0] = 1'b0;
      exp_words[0] += 10;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("reset_mid_v_o", 128'(vo[0]), 128'(0));
      run(0, 1, 0, 100);

      // other widths, random ready
      run(2, 2, 2, 300);
      run(3, 1, 0, 200);
      run(3, 2, 2, 800);

      guard = 0;
      while (vo != 4'b0 && guard < 200) begin
         guard++;
         @(posedge clk); #1;
      end
      chk("drain", 128'(vo), 128'(0));
      chk("words0", 128'(g_dut[0].words), 128'(exp_words[0]));
      chk("words1", 128'(g_dut[1].words), 128'(exp_words[1]));
      chk("words2", 128'(g_dut[2].words), 128'(exp_words[2]));
      chk("words3", 128'(g_dut[3].words), 128'(exp_words[3]));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
